// File: rtl/paddle_ctrl.sv
// paddle_ctrl: buffers debounced press strobes per player and applies them to the paddle rows once per frame.
// Optional macro PADDLE_CENTER_EN adds center_i, which recentres both paddles at the next frame_tick.
module paddle_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 64,
  parameter int STEP     = 16,
  parameter int PEND_MAX = 3,
  parameter int Y_W      = 10
) (
  input  logic           pixel_clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           game_run,
`ifdef PADDLE_CENTER_EN
  input  logic           center_i,
`endif
  input  logic           PlayerA_up_i,
  input  logic           PlayerA_down_i,
  input  logic           PlayerB_up_i,
  input  logic           PlayerB_down_i,
  output logic [Y_W-1:0] PlayerA_y_o,
  output logic [Y_W-1:0] PlayerB_y_o,
  output logic           PlayerA_moved_o,
  output logic           PlayerB_moved_o
);

  localparam int PW = $clog2(PEND_MAX + 1) + 1;
  localparam int SW = Y_W + 2;
  localparam logic [Y_W-1:0]       YMID     = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic signed [SW-1:0] YMAX_S   = SW'(SCREEN_H - PADDLE_H);
  localparam logic signed [SW-1:0] STEP_S   = SW'(STEP);
  localparam logic signed [PW-1:0] PEND_HI  = PW'(PEND_MAX);
  localparam logic signed [PW-1:0] PEND_LO  = -PEND_HI;
  localparam logic signed [PW-1:0] PEND_ONE = 1;

  typedef enum logic [1:0] {IDLE, APPLY, COMMIT} state_t;

  state_t                 state;
  logic signed [PW-1:0]   pendA, pendB;
  logic signed [PW-1:0]   workA, workB;
  logic        [Y_W-1:0]  tgtA, tgtB;
  logic                   tickGo;

  // Saturating step count; simultaneous up and down cancel.
  function automatic logic signed [PW-1:0] satStep(input logic signed [PW-1:0] pend,
                                                   input logic up, input logic down);
    logic signed [PW-1:0] res;
    res = pend;
    if (down && !up && (pend != PEND_HI)) res = pend + PEND_ONE;
    if (up && !down && (pend != PEND_LO)) res = pend - PEND_ONE;
    return res;
  endfunction

  function automatic logic [Y_W-1:0] clampY(input logic [Y_W-1:0] y,
                                            input logic signed [PW-1:0] pend);
    logic signed [SW-1:0] target;
    target = $signed({2'b00, y}) + SW'(pend) * STEP_S;
    if (target < 0)      return '0;
    if (target > YMAX_S) return Y_W'(YMAX_S);
    return target[Y_W-1:0];
  endfunction

`ifdef PADDLE_CENTER_EN
  logic centerReq, centerWork;
  assign tickGo = frame_tick && (game_run || centerReq);
`else
  assign tickGo = frame_tick && game_run;
`endif

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pendA           <= '0;
      pendB           <= '0;
      workA           <= '0;
      workB           <= '0;
      tgtA            <= YMID;
      tgtB            <= YMID;
      PlayerA_y_o     <= YMID;
      PlayerB_y_o     <= YMID;
      PlayerA_moved_o <= 1'b0;
      PlayerB_moved_o <= 1'b0;
`ifdef PADDLE_CENTER_EN
      centerReq       <= 1'b0;
      centerWork      <= 1'b0;
`endif
    end else begin
      PlayerA_moved_o <= 1'b0;
      PlayerB_moved_o <= 1'b0;
      if (!game_run) begin
        pendA <= '0;
        pendB <= '0;
      end else begin
        pendA <= satStep(pendA, PlayerA_up_i, PlayerA_down_i);
        pendB <= satStep(pendB, PlayerB_up_i, PlayerB_down_i);
      end
`ifdef PADDLE_CENTER_EN
      if (center_i) centerReq <= 1'b1;
`endif
      case (state)
        // Snapshot: strobes arriving with the tick start the next frame's count.
        IDLE: begin
          if (tickGo) begin
            workA <= pendA;
            workB <= pendB;
            if (game_run) begin
              pendA <= satStep('0, PlayerA_up_i, PlayerA_down_i);
              pendB <= satStep('0, PlayerB_up_i, PlayerB_down_i);
            end
`ifdef PADDLE_CENTER_EN
            centerWork <= centerReq;
            centerReq  <= center_i;
`endif
            state <= APPLY;
          end
        end
        // Compute clamped targets.
        APPLY: begin
`ifdef PADDLE_CENTER_EN
          if (centerWork) begin
            tgtA <= YMID;
            tgtB <= YMID;
          end else
`endif
          begin
            tgtA <= clampY(PlayerA_y_o, workA);
            tgtB <= clampY(PlayerB_y_o, workB);
          end
          state <= COMMIT;
        end
        // Commit targets and flag real changes.
        COMMIT: begin
          PlayerA_y_o     <= tgtA;
          PlayerB_y_o     <= tgtB;
          PlayerA_moved_o <= (tgtA != PlayerA_y_o);
          PlayerB_moved_o <= (tgtB != PlayerB_y_o);
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: frame table, directed corner sequences and a randomized run against a frame-level model.
module tb_paddle_ctrl;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_run = 1'b0;
  logic       aUp = 1'b0, aDn = 1'b0, bUp = 1'b0, bDn = 1'b0;
`ifdef PADDLE_CENTER_EN
  logic       center = 1'b0;
`endif
  logic [9:0] aY, bY;
  logic       aMoved, bMoved;

  int checks = 0;
  int failures = 0;

  // Frame-level reference: integer positions, pending counts and a commit countdown.
  int mAy, mBy, mAp, mBp, mAt, mBt, mCnt;
  bit mAm, mBm;
  int curA, curB;

  typedef struct {
    bit run;
    int aUp, aDn, bUp, bDn;
    int expA, expB;
    bit mA, mB;
  } fvec_t;

  fvec_t tbl[10];

  always #5 pixel_clk = ~pixel_clk;

  paddle_ctrl dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .game_run       (game_run),
`ifdef PADDLE_CENTER_EN
    .center_i       (center),
`endif
    .PlayerA_up_i   (aUp),
    .PlayerA_down_i (aDn),
    .PlayerB_up_i   (bUp),
    .PlayerB_down_i (bDn),
    .PlayerA_y_o    (aY),
    .PlayerB_y_o    (bY),
    .PlayerA_moved_o(aMoved),
    .PlayerB_moved_o(bMoved)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clampY(input int v);
    if (v < 0) return 0;
    if (v > 416) return 416;
    return v;
  endfunction

  function automatic int satP(input int v);
    if (v > 3) return 3;
    if (v < -3) return -3;
    return v;
  endfunction

  task automatic modelReset();
    mAy = 208; mBy = 208; mAp = 0; mBp = 0; mCnt = 0; mAm = 0; mBm = 0;
    mAt = 208; mBt = 208; curA = 208; curB = 208;
  endtask

  task automatic modelEdge();
    bit go;
    int baseA, baseB;
    go = (mCnt == 0) && frame_tick && game_run;
    mAm = 0; mBm = 0;
    if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) begin
        mAm = (mAt != mAy); mBm = (mBt != mBy);
        mAy = mAt; mBy = mBt;
      end
    end
    if (go) begin
      mAt = clampY(mAy + mAp * 16);
      mBt = clampY(mBy + mBp * 16);
      mCnt = 2;
    end
    baseA = go ? 0 : mAp;
    baseB = go ? 0 : mBp;
    mAp = game_run ? satP(baseA + int'(aDn) - int'(aUp)) : 0;
    mBp = game_run ? satP(baseB + int'(bDn) - int'(bUp)) : 0;
  endtask

  task automatic cycle(input bit tick, input bit run, input bit au, input bit ad,
                       input bit bu, input bit bd, input bit cmp);
    frame_tick = tick; game_run = run; aUp = au; aDn = ad; bUp = bu; bDn = bd;
    @(posedge pixel_clk);
    modelEdge();
    @(negedge pixel_clk);
    if (cmp) begin
      check("rand_ay", aY, mAy);
      check("rand_by", bY, mBy);
      check("rand_am", aMoved, mAm);
      check("rand_bm", bMoved, mBm);
    end
    frame_tick = 0; aUp = 0; aDn = 0; bUp = 0; bDn = 0;
  endtask

  task automatic tickCheck(input string nm, input bit run, input bit adTick,
                           input int eA, input int eB, input bit mA, input bit mB);
    cycle(1, run, 0, adTick, 0, 0, 0);
    cycle(0, run, 0, 0, 0, 0, 0);
    check({nm, "_holdA"}, aY, curA);
    check({nm, "_holdB"}, bY, curB);
    check({nm, "_earlyMove"}, {aMoved, bMoved}, 0);
    cycle(0, run, 0, 0, 0, 0, 0);
    check({nm, "_ay"}, aY, eA);
    check({nm, "_by"}, bY, eB);
    check({nm, "_am"}, aMoved, mA);
    check({nm, "_bm"}, bMoved, mB);
    cycle(0, run, 0, 0, 0, 0, 0);
    check({nm, "_pulseEnd"}, {aMoved, bMoved}, 0);
    curA = eA; curB = eB;
  endtask

  task automatic runFrame(input fvec_t v, input int idx);
    int n;
    n = v.aUp;
    if (v.aDn > n) n = v.aDn;
    if (v.bUp > n) n = v.bUp;
    if (v.bDn > n) n = v.bDn;
    for (int i = 0; i < n; i++)
      cycle(0, v.run, i < v.aUp, i < v.aDn, i < v.bUp, i < v.bDn, 0);
    tickCheck($sformatf("frame%0d", idx), v.run, 0, v.expA, v.expB, v.mA, v.mB);
  endtask

  task automatic asyncReset();
    #2 reset = 1'b1;
    #1;
    check("rst_ay", aY, 208);
    check("rst_by", bY, 208);
    check("rst_moved", {aMoved, bMoved}, 0);
    @(negedge pixel_clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    tbl[0] = '{0, 2, 0, 0, 0, 208, 208, 0, 0};
    tbl[1] = '{1, 0, 2, 0, 0, 240, 208, 1, 0};
    tbl[2] = '{1, 0, 0, 5, 0, 240, 160, 0, 1};
    tbl[3] = '{1, 3, 0, 0, 3, 192, 208, 1, 1};
    tbl[4] = '{1, 3, 0, 0, 3, 144, 256, 1, 1};
    tbl[5] = '{1, 3, 0, 0, 3,  96, 304, 1, 1};
    tbl[6] = '{1, 3, 0, 0, 3,  48, 352, 1, 1};
    tbl[7] = '{1, 3, 0, 0, 3,   0, 400, 1, 1};
    tbl[8] = '{1, 3, 0, 0, 3,   0, 416, 0, 1};
    tbl[9] = '{1, 3, 0, 0, 3,   0, 416, 0, 0};

    modelReset();
    // Reset before any clock edge.
    asyncReset();
    cycle(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) runFrame(tbl[i], i);

    // Reset while the FSM is in APPLY discards the pending move.
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    asyncReset();
    cycle(0, 1, 0, 0, 0, 0, 0);
    tickCheck("postReset", 1, 0, 208, 208, 0, 0);

    // Up and down together cancel.
    cycle(0, 1, 1, 1, 0, 0, 0);
    tickCheck("cancel", 1, 0, 208, 208, 0, 0);

    // A press in the tick cycle belongs to the following frame.
    tickCheck("tickPress", 1, 1, 208, 208, 0, 0);
    tickCheck("tickPressNext", 1, 0, 224, 208, 1, 0);

    // Randomized run against the model.
    asyncReset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 15) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1);

`ifdef PADDLE_CENTER_EN
    asyncReset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 0);
      tickCheck($sformatf("ctrUp%0d", k), 1, 0, clampY(208 - 48 * (k + 1)), 208, 1, 0);
    end
    center = 1'b1;
    cycle(0, 1, 0, 0, 0, 1, 0);
    center = 1'b0;
    tickCheck("center", 1, 0, 208, 208, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
